bist_controller: RTL and testbench
==================================

Name: bist_controller

Overview:
- Sequencer for the logic-BIST datapath: test-pattern LFSR -> circuit under test -> 4-bit MISR signature compactor.
- On a start request it:
  - clears the MISR and seeds the LFSR;
  - runs a fixed number of pattern cycles;
  - freezes the MISR and compares the final signature against a golden value;
  - reports done/pass.
- Sits between the top-level test interface and the LFSR/MISR instances; it is the only driver of their control pins.

Parameters:
- PATTERN_COUNT, 15, number of pattern cycles applied; must be >= 1.
- SIG_WIDTH, 4, MISR signature width.
- GOLDEN_SIG, 4'b1010, expected fault-free signature, width SIG_WIDTH.
- CNT_WIDTH, $clog2(PATTERN_COUNT+1), pattern counter width; derived, not overridden.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  level-sampled start request.
- signature  in  SIG_WIDTH  current MISR contents.
- lfsr_load  out  1  one-cycle pulse; loads the LFSR seed.
- lfsr_en  out  1  advances the LFSR.
- misr_rst  out  1  one-cycle clear pulse to the MISR reset pin.
- misr_en  out  1  MISR capture enable / clock-gate enable.
- busy  out  1  high from INIT through COMPARE inclusive.
- done  out  1  high in DONE.
- pass  out  1  registered compare result; valid while done=1.
- pattern_cnt  out  CNT_WIDTH  patterns applied so far.

Behaviour:
- Reset values: all outputs 0, state IDLE, pattern_cnt 0, pass 0. Reset asserted in any state aborts immediately to these values; no partial result is retained.
- States: IDLE, INIT, RUN, COMPARE, DONE. All outputs are registered/Moore, decoded from state.
- IDLE:
  - start=1 at an edge -> INIT.
  - Otherwise stays in IDLE.
- INIT (1 cycle):
  - lfsr_load=1, misr_rst=1, busy=1; pattern_cnt cleared to 0.
  - Next edge -> RUN.
- RUN:
  - lfsr_en=1, misr_en=1, busy=1.
  - pattern_cnt increments each edge.
  - At the edge where pattern_cnt==PATTERN_COUNT-1: pattern_cnt becomes PATTERN_COUNT and state -> COMPARE.
  - RUN therefore lasts exactly PATTERN_COUNT cycles; PATTERN_COUNT=1 gives one RUN cycle.
- COMPARE (1 cycle):
  - lfsr_en=0, misr_en=0, busy=1; the signature is stable.
  - At the edge: pass <= (signature==GOLDEN_SIG); state -> DONE.
- DONE:
  - done=1; pass held; pattern_cnt holds PATTERN_COUNT.
  - start=1 -> INIT (rerun) and pass cleared to 0.
  - start=0 -> remain in DONE.
- start is ignored in INIT, RUN and COMPARE; there is no abort except reset.
- Latency: a start sampled at edge E gives done=1 after edge E+PATTERN_COUNT+2.
- Held start re-arms automatically from DONE; each run still shows at least 1 cycle of done.
- No arithmetic overflow: pattern_cnt never exceeds PATTERN_COUNT.

Optional Feature:
- Macro: BIST_SIG_CAPTURE_EN.
- Defined:
  - Extra output port sig_captured [SIG_WIDTH-1:0], reset 0.
  - Loaded with signature at the COMPARE edge; held until the next COMPARE or reset.
  - Cleared in INIT.
- Undefined: port and register are absent; all other behaviour is identical.

Decomposition:
- Shared package bist_pkg:
  - state enum (IDLE, INIT, RUN, COMPARE, DONE) with 3-bit encoding;
  - default SIG_WIDTH;
  - default GOLDEN_SIG;
  - default PATTERN_COUNT.
- One natural sub-module: bist_pattern_counter (clear, enable, terminal-count flag at PATTERN_COUNT-1). The FSM and compare register stay in bist_controller.

Test Plan:
- Reset, then start pulse with PATTERN_COUNT=15 and signature stub 4'b1010:
  - INIT 1 cycle with lfsr_load=misr_rst=1;
  - RUN 15 cycles with lfsr_en=misr_en=1;
  - done=1 and pass=1 after edge E+17; pattern_cnt=15.
- Same run with signature=4'b0110: done=1, pass=0.
- Start toggled repeatedly during RUN: run length unchanged at 15 cycles; no restart.
- Reset asserted at RUN cycle 7: all outputs 0 asynchronously; state IDLE; new start gives a full 15-cycle run.
- PATTERN_COUNT=1, start held high continuously:
  - exactly 1 RUN cycle per run;
  - done high for exactly 1 cycle between runs;
  - pass cleared in each INIT.
- With BIST_SIG_CAPTURE_EN, signature=4'h3: sig_captured=4'h3 after COMPARE; it holds when signature changes to 4'hF in DONE; it is 0 after reset.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared definitions for the logic-BIST sequencer: state encoding and
// default geometry of the pattern run and signature compare.
package bist_pkg;

  localparam int         DEF_PATTERN_COUNT = 15;
  localparam int         DEF_SIG_WIDTH     = 4;
  localparam logic [3:0] DEF_GOLDEN_SIG    = 4'b1010;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_RUN     = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/bist_pattern_counter.sv
// Counts applied BIST patterns; clear has priority over enable.
// Flags the terminal cycle (count == PATTERN_COUNT-1) combinationally.
// The controller stops enabling at PATTERN_COUNT, so the count never wraps.
module bist_pattern_counter #(
  parameter int PATTERN_COUNT = 15,
  parameter int CNT_WIDTH     = $clog2(PATTERN_COUNT + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 terminal
);

  assign terminal = (count == CNT_WIDTH'(PATTERN_COUNT - 1));

  // Pattern count register: cleared on run entry, advanced once per RUN cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/bist_controller.sv
// Logic-BIST sequencer: seeds LFSR, clears MISR, runs PATTERN_COUNT cycles,
// freezes the MISR and compares its signature against GOLDEN_SIG.
// Optional macro BIST_SIG_CAPTURE_EN adds a sig_captured output holding the last compared signature.
import bist_pkg::*;

module bist_controller #(
  parameter int                   PATTERN_COUNT = DEF_PATTERN_COUNT,
  parameter int                   SIG_WIDTH     = DEF_SIG_WIDTH,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG    = SIG_WIDTH'(DEF_GOLDEN_SIG),
  localparam int                  CNT_WIDTH     = $clog2(PATTERN_COUNT + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SIG_WIDTH-1:0] signature,
  output logic                 lfsr_load,
  output logic                 lfsr_en,
  output logic                 misr_rst,
  output logic                 misr_en,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_WIDTH-1:0] pattern_cnt
`ifdef BIST_SIG_CAPTURE_EN
  ,
  output logic [SIG_WIDTH-1:0] sig_captured
`endif
);

  state_t state;
  state_t state_next;
  logic   cnt_clear;
  logic   cnt_enable;
  logic   cnt_terminal;

  bist_pattern_counter #(
    .PATTERN_COUNT (PATTERN_COUNT),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_pattern_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .count    (pattern_cnt),
    .terminal (cnt_terminal)
  );

  // State register; reset aborts any run in progress straight to IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and Moore output decode; start only matters in IDLE and DONE.
  always_comb begin
    state_next = state;
    lfsr_load  = 1'b0;
    lfsr_en    = 1'b0;
    misr_rst   = 1'b0;
    misr_en    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_INIT;
      end
      ST_INIT: begin
        lfsr_load  = 1'b1;
        misr_rst   = 1'b1;
        busy       = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        lfsr_en = 1'b1;
        misr_en = 1'b1;
        busy    = 1'b1;
        if (cnt_terminal) state_next = ST_COMPARE;
      end
      ST_COMPARE: begin
        busy       = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) state_next = ST_INIT;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Counter is zeroed on the edge entering INIT so INIT already shows 0.
  assign cnt_clear  = (state_next == ST_INIT);
  assign cnt_enable = (state == ST_RUN);

  // Compare result: captured while the MISR is frozen, dropped when a rerun starts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pass <= 1'b0;
    end else if (state == ST_COMPARE) begin
      pass <= (signature == GOLDEN_SIG);
    end else if (state_next == ST_INIT) begin
      pass <= 1'b0;
    end
  end

`ifdef BIST_SIG_CAPTURE_EN
  // Signature snapshot taken at the compare edge for debug readout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sig_captured <= '0;
    end else if (state == ST_COMPARE) begin
      sig_captured <= signature;
    end else if (state_next == ST_INIT) begin
      sig_captured <= '0;
    end
  end
`else
  // No signature snapshot register in this build.
`endif

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller: two instances (PATTERN_COUNT 15 and 1) checked
// every cycle against a run-offset model, plus literal expectations.
module tb_bist_controller;

  localparam logic [3:0] GOLDEN = 4'b1010;

  logic       clock;
  logic       reset;
  logic       start1, start2;
  logic [3:0] sig1, sig2;
  logic       load1, en1, mrst1, men1, busy1, done1, pass1;
  logic       load2, en2, mrst2, men2, busy2, done2, pass2;
  logic [3:0] cnt1;
  logic [0:0] cnt2;
`ifdef BIST_SIG_CAPTURE_EN
  logic [3:0] cap1, cap2;
`endif

  int passed = 0;
  int total  = 0;

  // Model: mt = cycles since the accepted start (1 = seed/clear cycle), -1 = idle after reset.
  int         mt[2];
  bit         mpass[2];
  logic [3:0] mcap[2];
  int         pc[2];

  bist_controller dut1 (
    .clock(clock), .reset(reset), .start(start1), .signature(sig1),
    .lfsr_load(load1), .lfsr_en(en1), .misr_rst(mrst1), .misr_en(men1),
    .busy(busy1), .done(done1), .pass(pass1), .pattern_cnt(cnt1)
`ifdef BIST_SIG_CAPTURE_EN
    , .sig_captured(cap1)
`endif
  );

  bist_controller #(.PATTERN_COUNT(1)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .signature(sig2),
    .lfsr_load(load2), .lfsr_en(en2), .misr_rst(mrst2), .misr_en(men2),
    .busy(busy2), .done(done2), .pass(pass2), .pattern_cnt(cnt2)
`ifdef BIST_SIG_CAPTURE_EN
    , .sig_captured(cap2)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // {lfsr_load, lfsr_en, misr_rst, misr_en, busy, done, pass} for a given run offset.
  function automatic logic [6:0] exp_ctl(int t, int p, bit ps);
    if (t < 1)        return 7'b0000000;
    if (t == 1)       return 7'b1010100;
    if (t <= p + 1)   return 7'b0101100;
    if (t == p + 2)   return 7'b0000100;
    return {6'b000001, ps};
  endfunction

  function automatic int exp_cnt(int t, int p);
    if (t <= 1)     return 0;
    if (t <= p + 1) return t - 2;
    return p;
  endfunction

  task automatic step_model(input int k, input logic st, input logic [3:0] sg);
    int p;
    p = pc[k];
    if (reset) begin
      mt[k] = -1; mpass[k] = 1'b0; mcap[k] = 4'h0;
    end else if (mt[k] < 0 || mt[k] >= p + 3) begin
      if (st) begin
        mt[k] = 1; mpass[k] = 1'b0; mcap[k] = 4'h0;
      end
    end else begin
      if (mt[k] == p + 2) begin
        mpass[k] = (sg == GOLDEN);
        mcap[k]  = sg;
      end
      mt[k]++;
    end
  endtask

  // Advance the model on each rising edge using the inputs the DUTs sample.
  always @(posedge clock) begin
    step_model(0, start1, sig1);
    step_model(1, start2, sig2);
  end

  // Compare every cycle on the falling edge, away from input changes.
  always @(negedge clock) begin
    chk("ctl1", {load1, en1, mrst1, men1, busy1, done1, pass1}, exp_ctl(mt[0], pc[0], mpass[0]));
    chk("cnt1", cnt1, exp_cnt(mt[0], pc[0]));
    chk("ctl2", {load2, en2, mrst2, men2, busy2, done2, pass2}, exp_ctl(mt[1], pc[1], mpass[1]));
    chk("cnt2", cnt2, exp_cnt(mt[1], pc[1]));
`ifdef BIST_SIG_CAPTURE_EN
    chk("cap1", cap1, mcap[0]);
    chk("cap2", cap2, mcap[1]);
`endif
  end

  task automatic nxt();
    @(negedge clock);
    #1;
  endtask

  // One full PATTERN_COUNT=15 run on dut1 with literal timing checks; optional start toggling.
  task automatic run1(input logic [3:0] sg, input bit toggle, input bit exp_pass);
    int run_cycles;
    sig1 = sg;
    start1 = 1'b1;
    nxt();
    start1 = 1'b0;
    chk("init_load", {load1, mrst1, busy1}, 3'b111);
    chk("init_cnt", cnt1, 0);
    run_cycles = 0;
    for (int i = 1; i <= 17; i++) begin
      if (toggle && i <= 14) start1 = 1'($urandom_range(0, 1));
      else start1 = 1'b0;
      nxt();
      if (en1 && men1) run_cycles++;
      if (i == 16) chk("compare_not_done", {done1, busy1, en1}, 3'b010);
    end
    chk("run_len", run_cycles, 15);
    chk("done_pass", {done1, pass1}, {1'b1, exp_pass});
    chk("done_cnt", cnt1, 15);
  endtask

  initial begin
    int ndone, nrun;
    bit prev_done;
    pc[0] = 15; pc[1] = 1;
    mt[0] = -1; mt[1] = -1;
    mpass[0] = 0; mpass[1] = 0;
    mcap[0] = 0; mcap[1] = 0;
    reset = 1'b1; start1 = 0; start2 = 0; sig1 = GOLDEN; sig2 = GOLDEN;
    repeat (3) nxt();
    chk("reset_outs", {load1, en1, mrst1, men1, busy1, done1, pass1, cnt1}, 11'h0);
    reset = 1'b0;
    nxt();

    // Golden signature, then a faulty one, then start chatter during RUN.
    run1(4'b1010, 1'b0, 1'b1);
    nxt();
    run1(4'b0110, 1'b0, 1'b0);
    nxt();
    run1(4'b1010, 1'b1, 1'b1);
    nxt();

    // Abort with reset in the seventh RUN cycle.
    start1 = 1'b1;
    nxt();
    start1 = 1'b0;
    repeat (7) nxt();
    chk("run7_busy", {busy1, en1}, 2'b11);
    reset = 1'b1;
    #1;
    chk("async_reset", {load1, en1, mrst1, men1, busy1, done1, pass1, cnt1}, 11'h0);
    nxt();
    reset = 1'b0;
    nxt();
    run1(4'b1010, 1'b0, 1'b1);

`ifdef BIST_SIG_CAPTURE_EN
    nxt();
    run1(4'h3, 1'b0, 1'b0);
    chk("cap_load", cap1, 4'h3);
    sig1 = 4'hF;
    repeat (2) nxt();
    chk("cap_hold", cap1, 4'h3);
    reset = 1'b1;
    nxt();
    chk("cap_reset", cap1, 4'h0);
    reset = 1'b0;
    nxt();
`endif

    // PATTERN_COUNT=1 with start held high: period of 4 cycles, one done each.
    start2 = 1'b1;
    repeat (6) nxt();
    ndone = 0; nrun = 0; prev_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sig2 = ($urandom_range(0, 1) != 0) ? GOLDEN : 4'($urandom);
      nxt();
      if (done2) ndone++;
      if (en2) nrun++;
      if (done2 && prev_done) chk("done_single", 1, 0);
      if (mrst2) chk("init_pass_clr", pass2, 0);
      prev_done = done2;
    end
    chk("p1_done_count", ndone, 10);
    chk("p1_run_count", nrun, 10);
    start2 = 1'b0;

    // Randomised traffic on both instances with occasional resets.
    for (int i = 0; i < 2500; i++) begin
      start1 = ($urandom_range(0, 4) == 0);
      start2 = ($urandom_range(0, 2) == 0);
      sig1 = ($urandom_range(0, 1) != 0) ? GOLDEN : 4'($urandom);
      sig2 = ($urandom_range(0, 1) != 0) ? GOLDEN : 4'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      nxt();
    end
    reset = 1'b0;
    nxt();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
